// File: rtl/fdiv_round_pkg.sv
// rtl/fdiv_round_pkg.sv - shared FPU types and constants for the fdiv rounding pipeline
package fdiv_round_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_t;

    typedef enum logic [1:0] {
        FC_NORMAL = 2'b00,
        FC_ZERO   = 2'b01,
        FC_INF    = 2'b10,
        FC_NAN    = 2'b11
    } fp_class_t;

    localparam logic [31:0] QNAN_BITS       = 32'h7fc00000;
    localparam logic [31:0] INF_BITS        = 32'h7f800000;
    localparam logic [31:0] MAX_FINITE_BITS = 32'h7f7fffff;

    // One pipeline slot; cls is the class of the final result, not of an operand
    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [9:0] exp;
        fp_class_t  cls;
        logic       invalid;
        logic       divzero;
        rm_t        rm;
    } stage_t;

endpackage

// File: rtl/fdiv_round_if.sv
// rtl/fdiv_round_if.sv - ID operand, divider quotient and W result bundle
interface fdiv_round_if;
    logic        ena;
    logic        fdiv;
    logic        stall;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [1:0]  rm;
    logic [31:0] q;
    logic [23:0] a_mant;
    logic [23:0] b_mant;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  flags;

    modport master (
        output ena, fdiv, stall, fa, fb, rm, q,
        input  a_mant, b_mant, result, result_valid, flags
    );

    modport slave (
        input  ena, fdiv, stall, fa, fb, rm, q,
        output a_mant, b_mant, result, result_valid, flags
    );
endinterface

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - classify one IEEE single operand and extract its mantissa
module fp_classify
    import fdiv_round_pkg::*;
(
    input  logic [31:0] op,
    output fp_class_t   cls,
    output logic        snan,
    output logic        sign,
    output logic [23:0] mant
);

    // Denormals collapse into the zero class; a NaN with a clear quiet bit is signalling
    always_comb begin
        cls  = FC_NORMAL;
        snan = 1'b0;
        if (op[30:23] == 8'h00) begin
            cls = FC_ZERO;
        end else if (op[30:23] == 8'hff) begin
            if (op[22:0] == 23'd0) begin
                cls = FC_INF;
            end else begin
                cls  = FC_NAN;
                snan = ~op[22];
            end
        end
    end

    assign sign = op[31];
    assign mant = {1'b1, op[22:0]};

endmodule

// File: rtl/fdiv_round.sv
// rtl/fdiv_round.sv - fdiv exponent/special tracking and final rounding, ID->E1->E2->E3->W
module fdiv_round
    import fdiv_round_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fdiv_round_if.slave  bus
);

    fp_class_t   cls_a;
    fp_class_t   cls_b;
    logic        snan_a;
    logic        snan_b;
    logic        sign_a;
    logic        sign_b;

    stage_t      id_stage;
    stage_t      e1_d, e1_q;
    stage_t      e2_d, e2_q;
    stage_t      e3_d, e3_q;

    logic [31:0] result_d, result_q;
    logic [4:0]  flags_d, flags_q;
    logic        result_valid_d, result_valid_q;

    logic [22:0] frac_n;
    logic [22:0] frac_r;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic        carry;
    logic [9:0]  exp_n;
    logic [9:0]  exp_r;
    logic [31:0] w_result;
    logic [4:0]  w_flags;

    fp_classify u_cls_a (
        .op   (bus.fa),
        .cls  (cls_a),
        .snan (snan_a),
        .sign (sign_a),
        .mant (bus.a_mant)
    );

    fp_classify u_cls_b (
        .op   (bus.fb),
        .cls  (cls_b),
        .snan (snan_b),
        .sign (sign_b),
        .mant (bus.b_mant)
    );

    // ID: resolve the result class and flags of special operands before entering E1
    always_comb begin
        id_stage.valid   = bus.fdiv & ~bus.stall;
        id_stage.sign    = sign_a ^ sign_b;
        id_stage.exp     = {2'b00, bus.fa[30:23]} - {2'b00, bus.fb[30:23]} + 10'd126;
        id_stage.rm      = rm_t'(bus.rm);
        id_stage.cls     = FC_NORMAL;
        id_stage.invalid = 1'b0;
        id_stage.divzero = 1'b0;
        if (cls_a == FC_NAN || cls_b == FC_NAN) begin
            id_stage.cls     = FC_NAN;
            id_stage.invalid = snan_a | snan_b;
        end else if ((cls_a == FC_ZERO && cls_b == FC_ZERO) ||
                     (cls_a == FC_INF  && cls_b == FC_INF)) begin
            id_stage.cls     = FC_NAN;
            id_stage.invalid = 1'b1;
        end else if (cls_a == FC_INF) begin
            id_stage.cls = FC_INF;
        end else if (cls_b == FC_ZERO) begin
            id_stage.cls     = FC_INF;
            id_stage.divzero = 1'b1;
        end else if (cls_a == FC_ZERO || cls_b == FC_INF) begin
            id_stage.cls = FC_ZERO;
        end
    end

    // E3 -> W: normalise the divider quotient, round, then range-check the exponent
    always_comb begin
        frac_n = q_frac(bus.q);
        guard  = bus.q[31] ? bus.q[7] : bus.q[6];
        sticky = bus.q[31] ? |bus.q[6:0] : |bus.q[5:0];
        exp_n  = e3_q.exp + {9'd0, bus.q[31]};

        inc = 1'b0;
        case (e3_q.rm)
            RM_RNE:  inc = guard & (sticky | frac_n[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~e3_q.sign & (guard | sticky);
            RM_RDN:  inc = e3_q.sign & (guard | sticky);
            default: inc = 1'b0;
        endcase

        // Hidden bit is implicit: an all-ones fraction plus one wraps to zero, i.e. 0x800000
        frac_r = frac_n + {22'd0, inc};
        carry  = inc & (&frac_n);
        exp_r  = exp_n + {9'd0, carry};

        w_result = 32'd0;
        w_flags  = 5'd0;
        case (e3_q.cls)
            FC_NAN: begin
                w_result   = QNAN_BITS;
                w_flags[4] = e3_q.invalid;
            end
            FC_INF: begin
                w_result   = {e3_q.sign, INF_BITS[30:0]};
                w_flags[3] = e3_q.divzero;
            end
            FC_ZERO: begin
                w_result = {e3_q.sign, 31'd0};
            end
            default: begin
                if ($signed(exp_r) >= 10'sd255) begin
                    w_flags = 5'b00101;
                    if (e3_q.rm == RM_RNE || (e3_q.rm == RM_RUP && !e3_q.sign) ||
                        (e3_q.rm == RM_RDN && e3_q.sign)) begin
                        w_result = {e3_q.sign, INF_BITS[30:0]};
                    end else begin
                        w_result = {e3_q.sign, MAX_FINITE_BITS[30:0]};
                    end
                end else if ($signed(exp_r) <= 10'sd0) begin
                    w_flags  = 5'b00011;
                    w_result = {e3_q.sign, 31'd0};
                end else begin
                    w_flags[0] = guard | sticky;
                    w_result   = {e3_q.sign, exp_r[7:0], frac_r};
                end
            end
        endcase
    end

    // Advance every stage on ena; W only overwrites result/flags when a real op arrives
    always_comb begin
        e1_d           = e1_q;
        e2_d           = e2_q;
        e3_d           = e3_q;
        result_d       = result_q;
        flags_d        = flags_q;
        result_valid_d = result_valid_q;
        if (bus.ena) begin
            e1_d           = id_stage;
            e2_d           = e1_q;
            e3_d           = e2_q;
            result_valid_d = e3_q.valid;
            if (e3_q.valid) begin
                result_d = w_result;
                flags_d  = w_flags;
            end
        end
    end

    // Pipeline registers; reset wipes all in-flight ops and the W outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            e1_q           <= '0;
            e2_q           <= '0;
            e3_q           <= '0;
            result_q       <= 32'd0;
            flags_q        <= 5'd0;
            result_valid_q <= 1'b0;
        end else begin
            e1_q           <= e1_d;
            e2_q           <= e2_d;
            e3_q           <= e3_d;
            result_q       <= result_d;
            flags_q        <= flags_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.flags        = flags_q;
    assign bus.result_valid = result_valid_q;

    function automatic logic [22:0] q_frac(input logic [31:0] qv);
        return qv[31] ? qv[30:8] : qv[29:7];
    endfunction

endmodule

// File: tb/tb_fdiv_round.sv
// tb/tb_fdiv_round.sv - directed self-checking bench for fdiv_round
module tb_fdiv_round;

    logic clk;
    logic rst;
    fdiv_round_if bus ();

    fdiv_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    logic        exp_valid;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;

    typedef struct {
        logic [31:0] fa;
        logic [31:0] fb;
        logic [1:0]  rm;
        logic [31:0] q;
        int          stage;
    } op_t;
    op_t pipe[$];

    typedef struct {
        logic [31:0] fa;
        logic [31:0] fb;
        logic [1:0]  rm;
        logic        has_q;
        logic [31:0] q;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Ideal divider: quotient of the 24-bit significands with one integer bit, sticky in bit 0
    function automatic logic [31:0] qdiv(input logic [31:0] a, input logic [31:0] b);
        longint unsigned n, d, quo;
        n   = {40'd0, 1'b1, a[22:0]};
        n   = n << 31;
        d   = {40'd0, 1'b1, b[22:0]};
        quo = n / d;
        return quo[31:0] | {31'd0, (n % d) != 0};
    endfunction

    // Reference: value = q * 2^(ea-eb-31); round by comparing the discarded remainder to one half
    function automatic logic [36:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] m, input logic [31:0] q);
        int ea, eb, e;
        logic s;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, up;
        longint unsigned sig, rem, half;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        s      = a[31] ^ b[31];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        if (a_nan || b_nan) return {(a_snan || b_snan) ? 5'b10000 : 5'b00000, 32'h7fc00000};
        if ((a_zero && b_zero) || (a_inf && b_inf)) return {5'b10000, 32'h7fc00000};
        if (a_inf) return {5'b00000, s, 31'h7f800000};
        if (b_zero) return {5'b01000, s, 31'h7f800000};
        if (a_zero || b_inf) return {5'b00000, s, 31'h0};
        if (q >= 32'h80000000) begin
            sig = longint'(q) >> 8; rem = longint'(q) & 64'hff; half = 64'h80; e = ea - eb + 127;
        end else begin
            sig = longint'(q) >> 7; rem = longint'(q) & 64'h7f; half = 64'h40; e = ea - eb + 126;
        end
        case (m)
            2'd0:    up = (rem > half) || (rem == half && sig[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !s && rem != 0;
            default: up = s && rem != 0;
        endcase
        sig = sig + longint'(up);
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255)
            return {5'b00101, (m == 0 || (m == 2 && !s) || (m == 3 && s)) ?
                    {s, 31'h7f800000} : {s, 31'h7f7fffff}};
        if (e <= 0) return {5'b00011, s, 31'h0};
        return {4'b0000, rem != 0, s, e[7:0], sig[22:0]};
    endfunction

    // Compare process: DUT outputs against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("result_valid", {63'd0, bus.result_valid}, {63'd0, exp_valid});
            check("result", {32'd0, bus.result}, {32'd0, exp_res});
            check("flags", {59'd0, bus.flags}, {59'd0, exp_flags});
        end
    end

    // One clock: drive ID and E3 quotient, then advance the model at the edge
    task automatic step(input logic r, input logic e, input logic f, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic has_q, input logic [31:0] qo);
        op_t op;
        logic [36:0] mr;
        rst       = r;
        bus.ena   = e;
        bus.fdiv  = f;
        bus.stall = s;
        bus.fa    = a;
        bus.fb    = b;
        bus.rm    = m;
        bus.q     = $urandom();
        foreach (pipe[i]) if (pipe[i].stage == 3) bus.q = pipe[i].q;
        #1;
        check("a_mant", {40'd0, bus.a_mant}, {40'd0, 1'b1, a[22:0]});
        check("b_mant", {40'd0, bus.b_mant}, {40'd0, 1'b1, b[22:0]});
        @(posedge clk);
        if (r) begin
            pipe.delete();
            exp_valid = 1'b0;
            exp_res   = 32'd0;
            exp_flags = 5'd0;
        end else if (e) begin
            exp_valid = 1'b0;
            for (int i = pipe.size() - 1; i >= 0; i--) begin
                if (pipe[i].stage == 3) begin
                    mr        = model_div(pipe[i].fa, pipe[i].fb, pipe[i].rm, pipe[i].q);
                    exp_res   = mr[31:0];
                    exp_flags = mr[36:32];
                    exp_valid = 1'b1;
                    pipe.delete(i);
                end
            end
            foreach (pipe[i]) pipe[i].stage = pipe[i].stage + 1;
            if (f && !s) begin
                op.fa = a; op.fb = b; op.rm = m;
                op.q = has_q ? qo : qdiv(a, b);
                op.stage = 1;
                pipe.push_back(op);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic e);
        step(1'b0, e, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                           input logic hq, input logic [31:0] qv,
                           input logic [31:0] res, input logic [4:0] flg);
        vec_t v;
        v.fa = a; v.fb = b; v.rm = m; v.has_q = hq; v.q = qv; v.res = res; v.flg = flg;
        vecs.push_back(v);
    endtask

    initial begin
        int nv, k, pulses, first;
        logic [36:0] mr;

        exp_valid = 1'b0;
        exp_res   = 32'd0;
        exp_flags = 5'd0;

        // Pin the model and the divider model with hand-computed values
        check("pin_q_6_2", {32'd0, qdiv(32'h40c00000, 32'h40000000)}, {32'd0, 32'hc0000000});
        check("pin_q_max_half", {32'd0, qdiv(32'h7f7fffff, 32'h3f000000)}, {32'd0, 32'hffffff00});
        mr = model_div(32'h40c00000, 32'h40000000, 2'd0, 32'hc0000000);
        check("pin_model_6_2", {27'd0, mr}, {27'd0, 5'b00000, 32'h40400000});
        mr = model_div(32'h3f800000, 32'h40400000, 2'd0, qdiv(32'h3f800000, 32'h40400000));
        check("pin_model_third_rne", {27'd0, mr}, {27'd0, 5'b00001, 32'h3eaaaaab});
        mr = model_div(32'h7f7fffff, 32'h3f000000, 2'd1, 32'hffffff00);
        check("pin_model_ovf_rtz", {27'd0, mr}, {27'd0, 5'b00101, 32'h7f7fffff});

        // Reset, once with ena low
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 32'd0);
        chk_en = 1'b1;
        check("reset_result", {32'd0, bus.result}, 64'd0);
        check("reset_valid", {63'd0, bus.result_valid}, 64'd0);
        check("reset_flags", {59'd0, bus.flags}, 64'd0);

        add_vec(32'h40c00000, 32'h40000000, 2'd0, 1'b0, 32'd0, 32'h40400000, 5'b00000);
        add_vec(32'h3f800000, 32'h40400000, 2'd0, 1'b0, 32'd0, 32'h3eaaaaab, 5'b00001);
        add_vec(32'h3f800000, 32'h40400000, 2'd1, 1'b0, 32'd0, 32'h3eaaaaaa, 5'b00001);
        add_vec(32'hbf800000, 32'h40400000, 2'd2, 1'b0, 32'd0, 32'hbeaaaaaa, 5'b00001);
        add_vec(32'hbf800000, 32'h40400000, 2'd3, 1'b0, 32'd0, 32'hbeaaaaab, 5'b00001);
        add_vec(32'h3f800000, 32'h00000000, 2'd0, 1'b0, 32'd0, 32'h7f800000, 5'b01000);
        add_vec(32'h00000000, 32'h00000000, 2'd0, 1'b0, 32'd0, 32'h7fc00000, 5'b10000);
        add_vec(32'h7f7fffff, 32'h3f000000, 2'd0, 1'b0, 32'd0, 32'h7f800000, 5'b00101);
        add_vec(32'h7f7fffff, 32'h3f000000, 2'd1, 1'b0, 32'd0, 32'h7f7fffff, 5'b00101);
        add_vec(32'h7f7fffff, 32'h3f000000, 2'd3, 1'b0, 32'd0, 32'h7f7fffff, 5'b00101);
        add_vec(32'hff7fffff, 32'h3f000000, 2'd3, 1'b0, 32'd0, 32'hff800000, 5'b00101);
        add_vec(32'h00800000, 32'h7f000000, 2'd0, 1'b0, 32'd0, 32'h00000000, 5'b00011);
        add_vec(32'h80400000, 32'h3f800000, 2'd0, 1'b0, 32'd0, 32'h80000000, 5'b00000);
        add_vec(32'h7f800001, 32'h3f800000, 2'd0, 1'b0, 32'd0, 32'h7fc00000, 5'b10000);
        add_vec(32'h7fc00000, 32'h3f800000, 2'd0, 1'b0, 32'd0, 32'h7fc00000, 5'b00000);
        add_vec(32'h7f800000, 32'h7f800000, 2'd0, 1'b0, 32'd0, 32'h7fc00000, 5'b10000);
        add_vec(32'h7f800000, 32'h00000000, 2'd0, 1'b0, 32'd0, 32'h7f800000, 5'b00000);
        add_vec(32'h40000000, 32'hff800000, 2'd0, 1'b0, 32'd0, 32'h80000000, 5'b00000);
        add_vec(32'h3f800000, 32'h3f800000, 2'd2, 1'b1, 32'hffffffff, 32'h40000000, 5'b00001);
        add_vec(32'h3f800000, 32'h3f800000, 2'd0, 1'b0, 32'd0, 32'h3f800000, 5'b00000);
        add_vec(32'h3f800000, 32'h3f800000, 2'd0, 1'b1, 32'h80000180, 32'h3f800002, 5'b00001);
        add_vec(32'h3f800000, 32'h3f800000, 2'd0, 1'b1, 32'h80000080, 32'h3f800000, 5'b00001);

        // Back-to-back issue; op k leaves W after step k+3
        nv = vecs.size();
        for (int j = 0; j < nv + 3; j++) begin
            if (j < nv)
                step(1'b0, 1'b1, 1'b1, 1'b0, vecs[j].fa, vecs[j].fb, vecs[j].rm,
                     vecs[j].has_q, vecs[j].q);
            else
                idle(1'b1);
            if (j >= 3) begin
                k = j - 3;
                check($sformatf("lit_valid_%0d", k), {63'd0, bus.result_valid}, 64'd1);
                check($sformatf("lit_result_%0d", k), {32'd0, bus.result}, {32'd0, vecs[k].res});
                check($sformatf("lit_flags_%0d", k), {59'd0, bus.flags}, {59'd0, vecs[k].flg});
            end
        end
        idle(1'b1);
        idle(1'b1);

        // Long stall with ena high, then a single accepted op
        for (int j = 0; j < 15; j++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40c00000, 32'h40000000, 2'd0, 1'b0, 32'd0);
        pulses = 0;
        first  = -1;
        for (int j = 0; j < 8; j++) begin
            if (j == 0) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h40c00000, 32'h40000000, 2'd0, 1'b0, 32'd0);
            else        idle(1'b1);
            if (bus.result_valid) begin
                pulses++;
                if (first < 0) first = j;
            end
        end
        check("stall_pulses", 64'(pulses), 64'd1);
        check("stall_latency", 64'(first), 64'd3);

        // ena low for three cycles while an op is in flight
        pulses = 0;
        first  = -1;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)               step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3f800000, 32'h40400000, 2'd1, 1'b0, 32'd0);
            else if (j >= 2 && j <= 4) idle(1'b0);
            else                      idle(1'b1);
            if (bus.result_valid && (first < 0 || j != first)) begin
                if (first < 0) first = j;
                pulses++;
            end
        end
        check("ena_gap_pulses", 64'(pulses), 64'd1);
        check("ena_gap_latency", 64'(first), 64'd6);

        // Reset while three ops occupy E1..E3
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3f800000, 32'h40400000, 2'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h40c00000, 32'h40000000, 2'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3f800000, 32'h00000000, 2'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 32'd0);
        check("midrst_result", {32'd0, bus.result}, 64'd0);
        pulses = 0;
        for (int j = 0; j < 7; j++) begin
            idle(1'b1);
            if (bus.result_valid) pulses++;
        end
        check("midrst_pulses", 64'(pulses), 64'd0);
        check("midrst_result_after", {32'd0, bus.result}, 64'd0);
        check("midrst_flags_after", {59'd0, bus.flags}, 64'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
